// File: rtl/fetch_sequencer.sv
// Y86-64 SEQ fetch front end: reads instruction bytes one at a time over a req/ack port,
// decodes fields and valP, and hands the instruction downstream through a valid/ready handshake.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MAX_LEN  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] newpc,
    input  logic        pc_load,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc,
    output logic        imem_error,
    output logic        instr_invalid,
    output logic        halted
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {FETCH, OUT, WAIT_PC, HALT} state_t;

    state_t          state, state_next;
    logic [63:0]     pc_q;
    logic [63:0]     valp_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   len;
    logic [7:0]      ibuf [MAX_LEN];
    logic            err_q;
    logic            capture;
    logic            fetch_done;
    logic            has_reg;

    function automatic logic [CW-1:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       instr_len = CW'(1);
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = CW'(2);
            4'h7, 4'h8:             instr_len = CW'(9);
            4'h3, 4'h4, 4'h5:       instr_len = CW'(10);
            default:                instr_len = CW'(1);
        endcase
    endfunction

    // Length is only meaningful once byte0 is in the buffer, hence the cnt != 0 guard.
    assign len        = instr_len(ibuf[0][7:4]);
    assign fetch_done = (cnt != '0) && (cnt == len);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        case (state)
            FETCH: begin
                if (fetch_done) begin
                    state_next = OUT;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        capture = 1'b1;
                        if (mem_err) state_next = OUT;
                    end
                end
            end
            OUT: begin
                instr_valid = 1'b1;
                if (instr_ready)
                    state_next = (icode == 4'h0 || err_q || instr_invalid) ? HALT : WAIT_PC;
            end
            WAIT_PC: if (pc_load) state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    // NOTE: the byte buffer is reset too; absent bytes must read as 0 and outputs must be defined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc_q   <= RESET_PC;
            valp_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) ibuf[i] <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                for (int i = 0; i < MAX_LEN; i++)
                    if (cnt == CW'(i)) ibuf[i] <= mem_err ? 8'h00 : mem_rdata;
                cnt <= cnt + CW'(1);
                if (mem_err) err_q <= 1'b1;
            end
            if (state == FETCH && state_next == OUT)
                valp_q <= pc_q + 64'(len);
            if (state == WAIT_PC && pc_load) begin
                pc_q   <= newpc;
                cnt    <= '0;
                err_q  <= 1'b0;
                valp_q <= '0;
                for (int i = 0; i < MAX_LEN; i++) ibuf[i] <= '0;
            end
        end
    end

    always_comb begin
        case (icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
            default:                                  has_reg = 1'b0;
        endcase
    end

    always_comb begin
        valC = '0;
        case (icode)
            4'h7, 4'h8:       for (int k = 0; k < 8; k++) valC[8*k +: 8] = ibuf[k+1];
            4'h3, 4'h4, 4'h5: for (int k = 0; k < 8; k++) valC[8*k +: 8] = ibuf[k+2];
            default:          valC = '0;
        endcase
    end

    assign icode         = ibuf[0][7:4];
    assign ifun          = ibuf[0][3:0];
    assign rA            = has_reg ? ibuf[1][7:4] : 4'hF;
    assign rB            = has_reg ? ibuf[1][3:0] : 4'hF;
    assign valP          = valp_q;
    assign pc            = pc_q;
    assign mem_addr      = pc_q + 64'(cnt);
    assign imem_error    = err_q;
    assign instr_invalid = icode > 4'hB;
    assign halted        = (state == HALT);

endmodule
